// File: rtl/order_serializer.sv
// order_serializer
//   Turns 32-bit order words into 5-byte AXI-Stream frames:
//   a header byte followed by the word, most significant byte first.
//   A small FIFO absorbs order bursts while the link is stalled.
//   Orders that arrive when the FIFO is full are dropped and counted.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   order_packet   in   order word, sampled when order_valid=1
//   order_valid    in   single-cycle strobe (no backpressure upstream)
//   m_axis_tdata   out  frame byte
//   m_axis_tvalid  out  byte valid
//   m_axis_tready  in   downstream accept
//   m_axis_tlast   out  final byte of a frame
//   fifo_count     out  queued words (excludes the word in the shifter)
//   drop_count     out  dropped orders, saturating at 16'hFFFF
//   busy           out  FSM not idle
module order_serializer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  HDR_BYTE   = 8'h4F
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   order_packet,
  input  logic                          order_valid,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_B3, S_B2, S_B1, S_B0
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_drop;
  logic [31:0]     r_shift;

  logic            w_full;
  logic            w_empty;
  logic            w_wr;
  logic            w_pop;
  logic            w_hs;
  logic            w_tvalid;
  logic            w_tlast;
  logic [7:0]      w_tdata;

  // Fullness is judged on the count before this edge, so a pop on the
  // same edge never rescues a write that arrives while full.
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr    = order_valid && !w_full;
  assign w_hs    = w_tvalid && m_axis_tready;

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_next;
      if (w_wr)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (order_valid && w_full && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  // Data storage: not reset, contents are meaningless until written
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= order_packet;
    if (w_pop)
      r_shift <= r_mem[r_rptr];
  end

  // Next state and outputs are decoded from registered state only, so
  // tdata/tlast cannot move while a beat is stalled.
  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_tvalid = 1'b1;
    w_tlast  = 1'b0;
    w_tdata  = '0;
    case (r_state)
      S_IDLE: begin
        w_tvalid = 1'b0;
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_HDR;
        end
      end
      S_HDR: begin
        w_tdata = HDR_BYTE;
        if (w_hs) w_next = S_B3;
      end
      S_B3: begin
        w_tdata = r_shift[31:24];
        if (w_hs) w_next = S_B2;
      end
      S_B2: begin
        w_tdata = r_shift[23:16];
        if (w_hs) w_next = S_B1;
      end
      S_B1: begin
        w_tdata = r_shift[15:8];
        if (w_hs) w_next = S_B0;
      end
      S_B0: begin
        w_tdata = r_shift[7:0];
        w_tlast = 1'b1;
        // Reload straight into the header so back-to-back frames have no gap
        if (w_hs) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = S_HDR;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: begin
        w_tvalid = 1'b0;
        w_next   = S_IDLE;
      end
    endcase
  end

  assign m_axis_tdata  = w_tdata;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tlast  = w_tlast;
  assign fifo_count    = r_count;
  assign drop_count    = r_drop;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_order_serializer.sv
// Bench for order_serializer: directed steps with a byte scoreboard.
module tb_order_serializer;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] order_packet;
  logic        order_valid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [15:0] drop_count;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  // expected beats: {tlast, tdata}
  logic [8:0] sb_q[$];
  logic       hold_act = 1'b0;
  logic [8:0] hold_val = '0;

  order_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .HDR_BYTE(8'h4F)) dut (
    .clk           (clk),
    .rst           (rst),
    .order_packet  (order_packet),
    .order_valid   (order_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_count    (fifo_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] w);
    sb_q.push_back({1'b0, 8'h4F});
    sb_q.push_back({1'b0, w[31:24]});
    sb_q.push_back({1'b0, w[23:16]});
    sb_q.push_back({1'b0, w[15:8]});
    sb_q.push_back({1'b1, w[7:0]});
  endtask

  task automatic strobe(input logic [31:0] w);
    order_packet = w;
    order_valid  = 1'b1;
    step();
    order_valid  = 1'b0;
  endtask

  // Run until the scoreboard is empty and the FSM is idle, bounded.
  task automatic drain(input bit rnd, input string tag);
    int cyc = 0;
    while ((sb_q.size() != 0 || busy) && cyc < 500) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      cyc++;
    end
    m_axis_tready = 1'b1;
    chk({tag, "_timeout"}, 32'(cyc >= 500), 32'd0);
  endtask

  // Monitor on the falling edge: compare accepted beats, check stall stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_act <= 1'b0;
    end else begin
      if (hold_act) begin
        chk("stall_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        chk("stall_beat_stable", 32'({m_axis_tlast, m_axis_tdata}), 32'(hold_val));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0)
          chk("unexpected_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'h1FF);
        else
          chk("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(sb_q.pop_front()));
        hold_act <= 1'b0;
      end else if (m_axis_tvalid) begin
        hold_act <= 1'b1;
        hold_val <= {m_axis_tlast, m_axis_tdata};
      end else begin
        hold_act <= 1'b0;
      end
    end
  end

  initial begin
    int cnt;
    rst           = 1'b1;
    order_packet  = '0;
    order_valid   = 1'b0;
    m_axis_tready = 1'b0;
    step();
    step();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_count",  32'(fifo_count),    32'd0);
    chk("rst_drop",   32'(drop_count),    32'd0);
    chk("rst_busy",   32'(busy),          32'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    step();

    // Single order, latency, fifo_count return
    push_frame(32'h12345678);
    strobe(32'h12345678);
    chk("lat_e_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("lat_e_count",  32'(fifo_count),    32'd1);
    step();
    chk("lat_e1_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("lat_e1_tdata",  32'(m_axis_tdata),  32'h4F);
    chk("lat_e1_count",  32'(fifo_count),    32'd0);
    drain(1'b0, "single");
    chk("single_count", 32'(fifo_count), 32'd0);

    // Backpressure with random tready
    m_axis_tready = 1'b0;
    push_frame(32'h12345678);
    strobe(32'h12345678);
    drain(1'b1, "bp");
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-to-back frames
    m_axis_tready = 1'b1;
    push_frame(32'hAABBCCDD);
    push_frame(32'h00000001);
    strobe(32'hAABBCCDD);
    strobe(32'h00000001);
    cnt = 0;
    while (!m_axis_tvalid && cnt < 10) begin
      step();
      cnt++;
    end
    chk("b2b_start_timeout", 32'(cnt >= 10), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_axis_tvalid) cnt++;
      step();
    end
    chk("b2b_contiguous", 32'(cnt), 32'd10);
    chk("b2b_idle_after", 32'(m_axis_tvalid), 32'd0);
    drain(1'b0, "b2b");

    // Overflow: six strobes with tready low
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) push_frame(32'(i));
      order_packet = 32'(i);
      order_valid  = 1'b1;
      step();
    end
    order_valid = 1'b0;
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_drop",  32'(drop_count), 32'd1);
    drain(1'b0, "ovf");
    chk("ovf_drop_after", 32'(drop_count), 32'd1);

    // Reset in B2 with two entries queued
    m_axis_tready = 1'b0;
    push_frame(32'h11223344);
    strobe(32'h11223344);
    strobe(32'h55667788);
    strobe(32'h99AABBCC);
    m_axis_tready = 1'b1;
    step();
    step();
    m_axis_tready = 1'b0;
    chk("mid_tdata_b2", 32'(m_axis_tdata), 32'h22);
    chk("mid_count",    32'(fifo_count),   32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("mid_rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("mid_rst_count",  32'(fifo_count),    32'd0);
    chk("mid_rst_drop",   32'(drop_count),    32'd0);
    chk("mid_rst_busy",   32'(busy),          32'd0);
    sb_q.delete();
    step();
    rst = 1'b0;
    m_axis_tready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_axis_tvalid) cnt++;
      step();
    end
    chk("post_rst_quiet", 32'(cnt), 32'd0);
    push_frame(32'hCAFEF00D);
    strobe(32'hCAFEF00D);
    drain(1'b0, "post_rst");

    // Drop counter saturation
    m_axis_tready = 1'b0;
    order_valid   = 1'b1;
    for (int i = 0; i < 65539; i++) begin
      order_packet = 32'(i);
      step();
    end
    chk("sat_fffe", 32'(drop_count), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(drop_count), 32'hFFFF);
    step();
    step();
    chk("sat_hold", 32'(drop_count), 32'hFFFF);
    chk("sat_count", 32'(fifo_count), 32'd4);
    order_valid = 1'b0;
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/order_serializer.md
# order_serializer

Serializes 32-bit order words from `order_gen` into an 8-bit AXI-Stream byte frame for the downstream transmit path. Each frame is one header byte followed by the order word, MSB first. The block sits directly downstream of `order_gen` and upstream of the MAC/transmit stage. A small FIFO absorbs order bursts while the link applies backpressure, and orders that arrive when the FIFO is full are dropped and counted.

## Interface
- `FIFO_DEPTH`, default 4: order-word FIFO entries; must be a power of 2, minimum 2.
- `HDR_BYTE`, default 8'h4F: first byte of every frame (ASCII 'O').
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `order_packet` in 32: order word; sampled only when `order_valid`=1.
- `order_valid` in 1: single-cycle strobe; no ready signal back to `order_gen`.
- `m_axis_tdata` out 8: frame byte.
- `m_axis_tvalid` out 1: byte valid.
- `m_axis_tready` in 1: downstream accept.
- `m_axis_tlast` out 1: high on the final byte of a frame.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of FIFO entries; excludes the frame currently in the shifter.
- `drop_count` out 16: orders dropped because the FIFO was full; saturates at 16'hFFFF.
- `busy` out 1: high when the FSM is not in IDLE.

## Operation
- **FIFO write:** on each edge with `order_valid`=1 and FIFO not full, write `order_packet`.
- **Full check:** fullness uses `fifo_count` before that edge's update. A write arriving when full is dropped even if a pop happens on the same edge. `drop_count` increments by 1 unless it is already 16'hFFFF.
- **Simultaneous write and pop:** when not full, both happen and `fifo_count` is unchanged.
- **FSM states:** IDLE, HDR, B3, B2, B1, B0.
- **IDLE:** if the FIFO is non-empty, pop the head into a 32-bit shift register and go to HDR.
- **HDR:** `tdata`=HDR_BYTE. On handshake (`tvalid`&&`tready`), go to B3.
- **B3/B2/B1/B0:** `tdata`=word[31:24], [23:16], [15:8], [7:0] respectively. Each state advances on handshake.
- **Leaving B0:** on handshake in B0, if the FIFO is non-empty, pop in the same cycle and go to HDR (no idle gap); otherwise go to IDLE.
- **tvalid:** `m_axis_tvalid`=1 in every state except IDLE.
- **tlast:** `m_axis_tlast`=1 only in B0.
- **AXI-Stream compliance:** `tdata` and `tlast` stay stable while `tvalid`&&!`tready`. `tvalid` never deasserts without a handshake.
- **busy:** `busy`=(state!=IDLE).
- **Pointers:** FIFO read/write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:** state=IDLE, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `fifo_count`=0, `drop_count`=0, `busy`=0, pointers=0.
- **Reset mid-frame:** the frame is truncated with no `tlast`. FIFO contents are discarded. `drop_count` clears.
- **Latency:** `order_valid` sampled at edge E (FIFO empty, FSM IDLE) → FIFO write at E; pop at E+1; HDR byte valid in the cycle after E+1 (2-cycle latency).
- **Frame duration:** 5 beats. With `tready` held at 1, back-to-back frames produce continuous beats.
- **Sustained rate:** maximum is one order per 5 cycles. Faster bursts beyond FIFO_DEPTH+1 orders (FIFO plus shifter) drop orders.
- **Drop count update:** `drop_count` is visible the cycle after the dropped strobe.

## Test plan
- **Single order:** 32'h12345678 with `tready`=1 → bytes 4F,12,34,56,78 on consecutive cycles; `tlast` only on 78; HDR valid 2 cycles after the strobe edge; `fifo_count` returns to 0.
- **Backpressure:** same order with `tready` pseudo-random (50%) → exactly 5 handshakes in order 4F,12,34,56,78. Bytes are held stable during stalls, with no repeats or skips.
- **Back-to-back frames:** two strobes one cycle apart (32'hAABBCCDD, 32'h00000001), `tready`=1 → 10 consecutive valid beats with no gap; `tlast` on DD and 01.
- **Overflow:** `tready`=0, FIFO_DEPTH=4, six consecutive strobes with values 1..6 → `fifo_count`=4 and `drop_count`=1. After releasing `tready`, five frames carry words 1..5 in order; word 6 is never sent.
- **Reset mid-frame:** assert `rst` in state B2 with 2 entries queued → all outputs at reset values immediately (asynchronously). After deassertion, no bytes appear until a new strobe arrives; that strobe yields a clean 5-byte frame.
- **Drop counter saturation:** force `drop_count` near 16'hFFFE via 3 drops past full → it stops at 16'hFFFF and does not wrap.
